memory_control: RTL

- Responder end of the CPU memory-request handshake. Accepts instruction-fetch and data read/write requests from the datapath's request logic.
- Serialises those requests onto a single fixed-latency RAM port. Returns one-cycle ihit/dhit pulses with load data.
- Sits between the datapath/request unit and the RAM model; data requests take priority over instruction fetches.

---
 rtl/memory_control.sv | 98 +++++++++
 1 files changed

// File: rtl/memory_control.sv
// memory_control: serialises instruction fetches and data accesses onto one fixed-latency RAM port.
// Define MEMCTL_ROUNDROBIN_EN to alternate data/fetch priority instead of fixed data-first.
`timescale 1ns/1ps
module memory_control #(
   parameter int RAM_LAT = 2,
   parameter int WORD_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic [WORD_W-1:0] dmemaddr,
   input  logic [WORD_W-1:0] dmemstore,
   output logic              ihit,
   output logic              dhit,
   output logic [WORD_W-1:0] imemload,
   output logic [WORD_W-1:0] dmemload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;
   localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);
   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_data;
   logic              r_write;
   logic [WORD_W-1:0] r_addr;
   logic [WORD_W-1:0] r_store;
   logic [WORD_W-1:0] r_iload;
   logic [WORD_W-1:0] r_dload;
   logic              w_dreq;
   logic              w_start;
   logic              w_pick_data;
   assign w_dreq  = dmemREN | dmemWEN;
   assign w_start = w_dreq | imemREN;
`ifdef MEMCTL_ROUNDROBIN_EN
   // r_last_data = 0 means the last access served was a fetch
   logic r_last_data;
   assign w_pick_data = w_dreq & (~imemREN | ~r_last_data);
   always_ff @(posedge CLK) begin
      if (RST)
         r_last_data <= 1'b0;
      else if (r_state == IDLE && w_start)
         r_last_data <= w_pick_data;
   end
`else
   assign w_pick_data = w_dreq;
`endif
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= 1'b0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_store <= '0;
         r_iload <= '0;
         r_dload <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_start) begin
               r_state <= ACCESS;
               r_cnt   <= LAT_M1;
               r_data  <= w_pick_data;
               r_write <= w_pick_data & dmemWEN;
               r_addr  <= w_pick_data ? dmemaddr : imemaddr;
               r_store <= w_pick_data ? dmemstore : '0;
            end
            ACCESS: begin
               r_cnt <= (r_cnt == 4'd0) ? 4'd0 : 4'(r_cnt - 4'd1);
               if (r_cnt == 4'd0) begin
                  r_state <= RESP;
                  if (!r_data)
                     r_iload <= ramload;
                  else if (!r_write)
                     r_dload <= ramload;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign ramREN   = (r_state == ACCESS) & ~r_write;
   assign ramWEN   = (r_state == ACCESS) & r_write;
   assign ramaddr  = r_addr;
   assign ramstore = r_store;
   assign ihit     = (r_state == RESP) & ~r_data;
   assign dhit     = (r_state == RESP) & r_data;
   assign imemload = r_iload;
   assign dmemload = r_dload;
endmodule
